// File: rtl/psec6_spi_pkg.sv
// ============================================================================
// Module      : psec6_spi_pkg
// Description : Shared types and constants for the SPI slave frame decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package psec6_spi_pkg;

  localparam int SPI_ADDR_W = 7;
  localparam int SPI_DATA_W = 8;

  localparam logic SPI_RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_CMD = 2'd0,
    S_WR  = 2'd1,
    S_RD  = 2'd2
  } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_frame_decoder_if.sv
// ============================================================================
// Module      : spi_frame_decoder_if
// Description : Pin / register-file bundle between the SPI pads and the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_frame_decoder_if
  import psec6_spi_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int DATA_W = SPI_DATA_W
);

  logic              mosi;
  logic [DATA_W-1:0] rd_data;
  logic              miso;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              rd_en;

  modport master (
    output mosi, rd_data,
    input  miso, addr, wr_data, wr_en, rd_en
  );

  modport slave (
    input  mosi, rd_data,
    output miso, addr, wr_data, wr_en, rd_en
  );

endinterface

`default_nettype wire

// File: rtl/spi_miso_shifter.sv
// ============================================================================
// Module      : spi_miso_shifter
// Description : Negedge load/shift register presenting readback data MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_miso_shifter
  import psec6_spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  wire logic              spi_clk,
  input  wire logic              full_rstn,
  input  wire logic              load,
  input  wire logic [DATA_W-1:0] rd_data,
  output logic                   miso
);

  logic [DATA_W-1:0] r_shift;

  always_ff @(negedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      r_shift <= '0;
    end else if (load) begin
      r_shift <= rd_data;
    end else begin
      r_shift <= {r_shift[DATA_W-2:0], 1'b0};
    end
  end

  assign miso = r_shift[DATA_W-1];

endmodule

`default_nettype wire

// File: rtl/spi_frame_decoder.sv
// ============================================================================
// Module      : spi_frame_decoder
// Description : SPI slave front end: header/data deserializer, strobes, MISO.
//               Define SPI_AUTO_INC_EN for burst address auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_decoder
  import psec6_spi_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int DATA_W = SPI_DATA_W
) (
  input wire logic       spi_clk,
  input wire logic       full_rstn,
  spi_frame_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);

  spi_state_e        r_state;
  spi_state_e        w_next_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-2:0] r_shift;
  logic [DATA_W-1:0] w_byte;
  logic              w_byte_done;
  logic              w_load_hdr;
  logic              w_wr_strobe;
  logic              w_rd_strobe;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_en;
  logic              r_rd_en;

  assign w_byte      = {r_shift, bus.mosi};
  assign w_byte_done = (r_bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Header decides direction once; the frame never returns to S_CMD.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CMD: begin
        if (w_byte_done) begin
          w_next_state = (w_byte[DATA_W-1] == SPI_RW_WRITE) ? S_WR : S_RD;
        end
      end
      default: w_next_state = r_state;
    endcase
  end

  always_comb begin
    w_load_hdr  = 1'b0;
    w_wr_strobe = 1'b0;
    w_rd_strobe = 1'b0;
    case (r_state)
      S_CMD: begin
        w_load_hdr  = w_byte_done;
        w_rd_strobe = w_byte_done && (w_byte[DATA_W-1] != SPI_RW_WRITE);
      end
      S_WR:    w_wr_strobe = w_byte_done;
      S_RD:    w_rd_strobe = w_byte_done;
      default: w_load_hdr  = 1'b0;
    endcase
  end

  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_bit_cnt <= w_byte_done ? '0 : r_bit_cnt + CNT_W'(1);
      r_shift   <= w_byte[DATA_W-2:0];
      r_wr_en   <= w_wr_strobe;
      r_rd_en   <= w_rd_strobe;
      if (w_wr_strobe) begin
        r_wr_data <= w_byte;
      end
    end
  end

  // Reads advance on the completing edge so the next byte is fetched at the
  // following negedge; writes advance one edge later, after wr_en is seen.
  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      r_addr <= '0;
    end else if (w_load_hdr) begin
      r_addr <= w_byte[ADDR_W-1:0];
`ifdef SPI_AUTO_INC_EN
    end else if ((r_state == S_RD && w_byte_done) || r_wr_en) begin
      r_addr <= r_addr + ADDR_W'(1);
`endif
    end
  end

  spi_miso_shifter #(
    .DATA_W (DATA_W)
  ) u_miso_shifter (
    .spi_clk   (spi_clk),
    .full_rstn (full_rstn),
    .load      (r_rd_en),
    .rd_data   (bus.rd_data),
    .miso      (bus.miso)
  );

  assign bus.addr    = r_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.wr_en   = r_wr_en;
  assign bus.rd_en   = r_rd_en;

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_decoder.sv
// ============================================================================
// Module      : tb_spi_frame_decoder
// Description : Directed scoreboard bench for spi_frame_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_frame_decoder;
  import psec6_spi_pkg::*;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic spi_clk   = 1'b0;
  logic full_rstn = 1'b0;

  spi_frame_decoder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spi_frame_decoder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .spi_clk   (spi_clk),
    .full_rstn (full_rstn),
    .bus       (bus)
  );

  always #5 spi_clk = ~spi_clk;

  function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
    return {1'b0, a} ^ 8'h30;
  endfunction

  // Register-file model: combinational readback of the current address.
  assign bus.rd_data = rd_model(bus.addr);

  exp_t              sb_q[$];
  bit                miso_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  bit                auto_inc;
  bit                cur_write;
  logic [ADDR_W-1:0] cur_addr;
  int                n_bytes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_miso(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = rd_model(a);
    for (int i = DATA_W - 1; i >= 0; i--) miso_q.push_back(v[i]);
  endtask

  task automatic check_strobes(input bit last);
    exp_t e;
    if (bus.wr_en || bus.rd_en) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 32'({bus.wr_en, bus.rd_en}), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("strobe_kind", 32'({bus.wr_en, bus.rd_en}), e.is_wr ? 32'd2 : 32'd1);
        check("strobe_addr", 32'(bus.addr), 32'(e.addr));
        if (e.is_wr) check("wr_data", 32'(bus.wr_data), 32'(e.data));
      end
    end
    if (last) check("missed_strobe", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic drive_bit(input logic b, input bit last, input bit miso_chk);
    bit m;
    @(negedge spi_clk);
    bus.mosi = b;
    @(posedge spi_clk);
    #1;
    if (miso_chk) begin
      if (miso_q.size() == 0) begin
        check("miso_underflow", 32'd1, 32'd0);
      end else begin
        m = miso_q.pop_front();
        check("miso", 32'(bus.miso), 32'(m));
      end
    end
    check_strobes(last);
  endtask

  task automatic start_frame();
    @(posedge spi_clk);
    #2;
    full_rstn = 1'b1;
  endtask

  task automatic end_frame();
    @(negedge spi_clk);
    full_rstn = 1'b0;
    #1;
    check("rst_addr",    32'(bus.addr),    32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_strobes", 32'({bus.wr_en, bus.rd_en}), 32'd0);
    check("rst_miso",    32'(bus.miso),    32'd0);
    sb_q.delete();
    miso_q.delete();
  endtask

  task automatic send_header(input logic [7:0] h);
    exp_t e;
    cur_write = h[7];
    cur_addr  = h[6:0];
    n_bytes   = 0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && !cur_write) begin
        e.is_wr = 1'b0; e.addr = cur_addr; e.data = '0;
        sb_q.push_back(e);
        push_miso(cur_addr);
      end
      drive_bit(h[i], i == 0, 1'b0);
    end
    check("hdr_addr", 32'(bus.addr), 32'(cur_addr));
  endtask

  task automatic send_data(input logic [7:0] d);
    exp_t              e;
    logic [ADDR_W-1:0] a;
    if (cur_write) a = auto_inc ? ADDR_W'(cur_addr + n_bytes)     : cur_addr;
    else           a = auto_inc ? ADDR_W'(cur_addr + n_bytes + 1) : cur_addr;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) begin
        e.is_wr = cur_write; e.addr = a; e.data = cur_write ? d : 8'h00;
        sb_q.push_back(e);
        if (!cur_write) push_miso(a);
      end
      drive_bit(d[i], i == 0, !cur_write);
    end
    n_bytes++;
  endtask

  initial begin
    logic [7:0] pat;
`ifdef SPI_AUTO_INC_EN
    auto_inc = 1'b1;
`else
    auto_inc = 1'b0;
`endif
    bus.mosi = 1'b0;

    repeat (2) @(posedge spi_clk);
    #1;
    check("init_addr",    32'(bus.addr),    32'd0);
    check("init_wr_data", 32'(bus.wr_data), 32'd0);
    check("init_strobes", 32'({bus.wr_en, bus.rd_en}), 32'd0);
    check("init_miso",    32'(bus.miso),    32'd0);

    // Single write, plus one trailing bit to see wr_en drop.
    start_frame();
    send_header(8'h8C);
    send_data(8'hA5);
    drive_bit(1'b0, 1'b0, 1'b0);
    check("wr_en_drop", 32'(bus.wr_en), 32'd0);
    end_frame();

    start_frame();
    send_header(8'hC3);
    send_data(8'h11);
    send_data(8'h22);
    send_data(8'h33);
    end_frame();

    start_frame();
    send_header(8'hFF);
    send_data(8'h5C);
    send_data(8'hC5);
    end_frame();

    start_frame();
    send_header(8'h0C);
    send_data(8'h00);
    send_data(8'hFF);
    end_frame();

    // Abort after 5 bits of the first data byte.
    start_frame();
    send_header(8'h8C);
    pat = 8'hFF;
    for (int i = 7; i >= 3; i--) drive_bit(pat[i], 1'b0, 1'b0);
    end_frame();
    repeat (2) begin
      @(posedge spi_clk);
      #1;
      check("abort_hold_wr_en", 32'(bus.wr_en), 32'd0);
    end
    start_frame();
    send_header(8'h8D);
    send_data(8'h5A);
    end_frame();

    // Reset during header bit 4, then a full single write.
    start_frame();
    pat = 8'h8C;
    for (int i = 7; i >= 4; i--) drive_bit(pat[i], 1'b0, 1'b0);
    end_frame();
    start_frame();
    send_header(8'h8C);
    send_data(8'hA5);
    end_frame();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
